// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset release sequencer and its users.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic POL_ACTIVE_HIGH = 1'b0;
  localparam logic POL_ACTIVE_LOW  = 1'b1;

  function automatic int cnt_w(input int hold, input int step);
    int m;
    m = (hold > step) ? hold : step;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Asserted level per channel: active-low channels assert at 0.
  function automatic logic [15:0] assert_mask(input logic [15:0] active_low);
    logic [15:0] m;
    for (int k = 0; k < 16; k++) begin
      m[k] = (active_low[k] == POL_ACTIVE_LOW) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-set, sync-release shift chain; output falls STAGES edges after in_rst drops.
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic in_rst,
  output logic rst_s
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign rst_s = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises the board reset and releases NUM_OUT domain resets one by one
// after a hold period; a software request or a resynchronised reset restarts it.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 NUM_OUT        = 4,
  parameter int                 HOLD_CYCLES    = 16,
  parameter int                 STEP_CYCLES    = 8,
  parameter logic [NUM_OUT-1:0] OUT_ACTIVE_LOW = '0
) (
  input  logic               clk,
  input  logic               in_rst,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] out_rst,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_w(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW = $clog2(NUM_OUT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'((STEP_CYCLES > 0) ? STEP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ASSERTED = NUM_OUT'(assert_mask(16'(OUT_ACTIVE_LOW)));

  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be 2..8");
  end
  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num
    $error("reset_sequencer: NUM_OUT must be 1..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be 1..65535");
  end
  if (STEP_CYCLES < 0 || STEP_CYCLES > 65535) begin : g_bad_step
    $error("reset_sequencer: STEP_CYCLES must be 0..65535");
  end

  logic rst_s;

  reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .in_rst (in_rst),
    .rst_s  (rst_s)
  );

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] out_rst_q, out_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    out_rst_d = out_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;

    // A resynchronised reset and a software request restart identically.
    if (rst_s || sw_rst_req) begin
      state_d   = HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      out_rst_d = ASSERTED;
      busy_d    = 1'b1;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (STEP_CYCLES == 0 || NUM_OUT == 1) begin
              out_rst_d = ~ASSERTED;
              state_d   = DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end else begin
              out_rst_d[0] = ~ASSERTED[0];
              idx_d        = IW'(1);
              state_d      = STEP;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STEP: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx_q == IW'(k)) out_rst_d[k] = ~ASSERTED[k];
            end
            idx_d = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      out_rst_q <= ASSERTED;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      out_rst_q <= out_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_rst = out_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default sequencer, a one-shot three-channel variant and a
// mixed-polarity variant share clock and inputs; each is checked against tables.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       sw_rst_req = 1'b0;

  logic [3:0] a_out, c_out;
  logic [2:0] b_out;
  logic       a_busy, a_done, b_busy, b_done, c_busy, c_done;

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  typedef struct {
    int         e;
    logic [3:0] out;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t full_tbl[13];
  vec_t rel_tbl[10];

  always #5 clk = ~clk;

  reset_sequencer dut_a (
    .clk(clk), .in_rst(in_rst), .sw_rst_req(sw_rst_req),
    .out_rst(a_out), .busy(a_busy), .done(a_done)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .NUM_OUT(3), .HOLD_CYCLES(4), .STEP_CYCLES(0)
  ) dut_b (
    .clk(clk), .in_rst(in_rst), .sw_rst_req(sw_rst_req),
    .out_rst(b_out), .busy(b_busy), .done(b_done)
  );

  reset_sequencer #(
    .OUT_ACTIVE_LOW(4'b0101)
  ) dut_c (
    .clk(clk), .in_rst(in_rst), .sw_rst_req(sw_rst_req),
    .out_rst(c_out), .busy(c_busy), .done(c_done)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b ({out,busy,done})", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    in_rst = 1'b0;
    ecount = 0;
  endtask

  task automatic check_ac(input string tag, input vec_t v);
    chk({"A ", tag}, {2'b00, a_out, a_busy, a_done}, {2'b00, v.out, v.busy, v.done});
    chk({"C ", tag}, {2'b00, c_out, c_busy, c_done},
        {2'b00, v.out ^ 4'b0101, v.busy, v.done});
  endtask

  task automatic run_full();
    for (int i = 0; i < 13; i++) begin
      while (ecount < full_tbl[i].e) tick();
      check_ac($sformatf("E%0d", full_tbl[i].e), full_tbl[i]);
      if (full_tbl[i].e >= 6)
        chk($sformatf("B E%0d", full_tbl[i].e), {3'b000, b_out, b_busy, b_done}, 8'b000_000_01);
      else
        chk($sformatf("B E%0d", full_tbl[i].e), {3'b000, b_out, b_busy, b_done}, 8'b000_111_10);
    end
  endtask

  // Offsets count from the last edge that sampled sw_rst_req high.
  task automatic run_rel(input string tag);
    int r = 0;
    for (int i = 0; i < 10; i++) begin
      while (r < rel_tbl[i].e) begin
        tick();
        r++;
      end
      check_ac($sformatf("%s R+%0d", tag, rel_tbl[i].e), rel_tbl[i]);
    end
  endtask

  initial begin
    full_tbl[0]  = '{0,  4'b1111, 1'b1, 1'b0};
    full_tbl[1]  = '{2,  4'b1111, 1'b1, 1'b0};
    full_tbl[2]  = '{5,  4'b1111, 1'b1, 1'b0};
    full_tbl[3]  = '{6,  4'b1111, 1'b1, 1'b0};
    full_tbl[4]  = '{17, 4'b1111, 1'b1, 1'b0};
    full_tbl[5]  = '{18, 4'b1110, 1'b1, 1'b0};
    full_tbl[6]  = '{25, 4'b1110, 1'b1, 1'b0};
    full_tbl[7]  = '{26, 4'b1100, 1'b1, 1'b0};
    full_tbl[8]  = '{33, 4'b1100, 1'b1, 1'b0};
    full_tbl[9]  = '{34, 4'b1000, 1'b1, 1'b0};
    full_tbl[10] = '{41, 4'b1000, 1'b1, 1'b0};
    full_tbl[11] = '{42, 4'b0000, 1'b0, 1'b1};
    full_tbl[12] = '{60, 4'b0000, 1'b0, 1'b1};

    rel_tbl[0] = '{0,  4'b1111, 1'b1, 1'b0};
    rel_tbl[1] = '{15, 4'b1111, 1'b1, 1'b0};
    rel_tbl[2] = '{16, 4'b1110, 1'b1, 1'b0};
    rel_tbl[3] = '{23, 4'b1110, 1'b1, 1'b0};
    rel_tbl[4] = '{24, 4'b1100, 1'b1, 1'b0};
    rel_tbl[5] = '{31, 4'b1100, 1'b1, 1'b0};
    rel_tbl[6] = '{32, 4'b1000, 1'b1, 1'b0};
    rel_tbl[7] = '{39, 4'b1000, 1'b1, 1'b0};
    rel_tbl[8] = '{40, 4'b0000, 1'b0, 1'b1};
    rel_tbl[9] = '{45, 4'b0000, 1'b0, 1'b1};

    #2 in_rst = 1'b1;
    #1;
    check_ac("async reset", full_tbl[0]);
    chk("B async reset", {3'b000, b_out, b_busy, b_done}, 8'b000_111_10);
    repeat (3) tick();

    // Power-on release: default timing, one-shot release and inverted channels.
    release_rst();
    run_full();

    // One-cycle software request while done.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    run_rel("pulse");

    // Request held high for 50 cycles keeps everything asserted.
    sw_rst_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("held %0d", i), {2'b00, a_out, a_busy, a_done}, 8'b00_1111_10);
    end
    sw_rst_req = 1'b0;
    run_rel("held");

    // Async in_rst while channel 2 is counting, then a full restart.
    @(negedge clk);
    in_rst = 1'b1;
    repeat (2) tick();
    release_rst();
    while (ecount < 30) tick();
    chk("pre-async E30", {2'b00, a_out, a_busy, a_done}, 8'b00_1100_10);
    #3 in_rst = 1'b1;
    #1;
    check_ac("mid-seq async", full_tbl[0]);
    repeat (3) tick();
    release_rst();
    run_full();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
